// File: rtl/brent_kung_adder.sv
// Registered WIDTH-bit adder, {carry,sum} = a + b + cin, carries from a Brent-Kung prefix tree.
// Define BRENT_KUNG_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module brent_kung_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  localparam int LOG2 = $clog2(WIDTH);
  localparam int NLVL = 2 * LOG2 - 1;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_vld;

`ifdef BRENT_KUNG_IN_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             vld_in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      vld_in_q <= 1'b0;
    end else begin
      a_q      <= a;
      b_q      <= b;
      cin_q    <= cin;
      vld_in_q <= in_valid;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
  assign op_vld = vld_in_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
  assign op_vld = in_valid;
`endif

  // Row 0 is the per-bit (G,P); rows 1..LOG2 are the up-sweep, the rest the down-sweep.
  logic [WIDTH-1:0] g_lvl [NLVL+1];
  logic [WIDTH-1:0] p_lvl [NLVL+1];

  always_comb begin
    g_lvl[0]    = op_a & op_b;
    p_lvl[0]    = op_a ^ op_b;
    g_lvl[0][0] = (op_a[0] & op_b[0]) | ((op_a[0] ^ op_b[0]) & op_cin);
  end

  for (genvar r = 1; r <= NLVL; r++) begin : g_row
    localparam bit UP = (r <= LOG2);
    localparam int S  = UP ? (1 << (r - 1)) : (1 << (2 * LOG2 - 1 - r));
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit COMBINE = UP ? (((i + 1) % (2 * S)) == 0)
                                  : ((((i + 1) % (2 * S)) == S) && ((i + 1) >= 3 * S));
      if (COMBINE) begin : g_op
        assign g_lvl[r][i] = g_lvl[r-1][i] | (p_lvl[r-1][i] & g_lvl[r-1][i-S]);
        assign p_lvl[r][i] = p_lvl[r-1][i] & p_lvl[r-1][i-S];
      end else begin : g_pass
        assign g_lvl[r][i] = g_lvl[r-1][i];
        assign p_lvl[r][i] = p_lvl[r-1][i];
      end
    end
  end

  // c[i+1] is the group generate of bits i..0, with cin already folded into bit 0.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign c       = {g_lvl[NLVL], op_cin};
  assign sum_d   = p_lvl[0] ^ c[WIDTH-1:0];
  assign carry_d = c[WIDTH];

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= op_vld;
      if (op_vld) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_brent_kung_adder.sv
// Scoreboard bench for brent_kung_adder: expected sums queued at drive time, popped on out_valid.
module tb_brent_kung_adder;

`ifdef BRENT_KUNG_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        in_valid;
  logic [15:0] sum;
  logic        carry;
  logic        out_valid;

  brent_kung_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] exp_q [$];
  logic        vpipe [LAT];
  logic        exp_valid;
  logic [16:0] last_exp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] ta,
                      input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      for (int i = 0; i < LAT; i++) vpipe[i] = 1'b0;
      last_exp = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) vpipe[i] = vpipe[i-1];
      vpipe[0] = v;
      if (v) exp_q.push_back({1'b0, ta} + {1'b0, tb_} + {16'd0, tc});
    end
    exp_valid = vpipe[LAT-1];
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid && exp_q.size() > 0) last_exp = exp_q.pop_front();
    check(exp_valid ? "result" : "hold", {15'd0, carry, sum}, {15'd0, last_exp});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    last_exp = '0;
    for (int i = 0; i < LAT; i++) vpipe[i] = 1'b0;

    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);

    step(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0);
    step(1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
    step(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0);
    step(1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b1);

    // A result still in flight when reset arrives must never appear.
    step(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 16'h3333, 16'h4444, 1'b1);

    for (int n = 0; n < 1000; n++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    for (int n = 0; n < LAT + 1; n++)
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/brent_kung_adder.md
Name: brent_kung_adder

Overview:
- Synchronous WIDTH-bit binary adder; carry computation uses a Brent-Kung parallel-prefix tree.
- Computes {carry, sum} = a + b + cin.
- Result is registered, so the block drops directly into a pipelined datapath.
- Default 16 bits; used wherever a fast log-depth carry chain is needed.

Parameters:
- WIDTH, 16, operand width; must be a power of two, 4 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- in_valid  input  1  operands valid this cycle
- sum  output  WIDTH  registered sum bits
- carry  output  1  registered carry-out (bit WIDTH of the result)
- out_valid  output  1  sum/carry hold a fresh result

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, sum=0, carry=0, out_valid=0. Reset takes priority over everything else.
- Mid-operation reset discards any in-flight result.
- Pre-processing, per bit i:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - cin is folded into bit 0 as G0 = g[0] | (p[0] & cin).
- Prefix tree:
  - Up-sweep: log2(WIDTH) levels. Level k combines (G,P) pairs at span 2^k on indices i where (i+1) is a multiple of 2^(k+1). Operator: (G,P) o (G',P') = (G | P&G', P&P').
  - Down-sweep: log2(WIDTH)-1 levels filling the remaining odd prefix positions.
  - Total logic depth: 2*log2(WIDTH)-1 prefix levels.
- Carries and outputs:
  - c[0] = cin; c[i+1] = group-generate G[i:0]
  - sum[i] = p[i] ^ c[i]
  - carry = c[WIDTH]
- Timing: purely combinational from a/b/cin to the register inputs. Latency is 1 cycle: operands sampled at edge N appear on sum/carry after edge N.
- out_valid at edge N equals in_valid sampled at edge N.
- Enable behaviour: sum/carry load only when in_valid=1. Otherwise they hold their previous value.
- Arithmetic: unsigned, modulo 2^WIDTH, with the overflow bit in carry. No signed overflow flag.
- Tree must be built with generate loops parameterised by WIDTH. A behavioural '+' operator is not permitted for the carry logic.

Optional Feature:
- Macro: BRENT_KUNG_IN_REG_EN.
- When defined:
  - a, b, cin and in_valid are first captured in an input register stage (reset to 0 by rst_n).
  - Latency becomes 2 cycles.
  - out_valid is delayed to match.
- When undefined: single output register stage, latency 1, as specified above.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=16'hFFFF, b=16'h0001 -> sum=0, carry=0, out_valid=0 throughout.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, carry=1, out_valid=1 one cycle later (two cycles with BRENT_KUNG_IN_REG_EN).
- cin only: a=0, b=0, cin=1 -> sum=16'h0001, carry=0.
- Max operands: a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, carry=1. No-carry case: a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, carry=0.
- Hold: after a valid result, drive in_valid=0 with new operands -> sum/carry unchanged, out_valid=0. Then assert rst_n=0 mid-stream -> outputs clear at the next edge.
- Random: 1000 random a, b, cin with in_valid=1 -> {carry,sum} equals a+b+cin (17-bit) each cycle, compared with the correct latency offset.
